// File: rtl/bayer_line_ctrl.sv
// Line-buffer sequencer for the 2x2 Bayer/greyscale path: tracks X/Y,
// primes one line into the FIFO, then streams and flags complete windows.
module bayer_line_ctrl #(
    parameter int LINE_WIDTH   = 1280,
    parameter int FRAME_HEIGHT = 960,
    parameter int CNT_W        = 11
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iFVAL,
    input  logic             iDVAL,
    input  logic             iFIFO_FULL,
    input  logic             iFIFO_EMPTY,
    output logic             oWREN,
    output logic             oRDEN,
    output logic             oFLUSH,
    output logic [CNT_W-1:0] oX_Cont,
    output logic [CNT_W-1:0] oY_Cont,
    output logic             oWIN_VALID,
    output logic             oFRAME_DONE,
    output logic [2:0]       oERR
);

    typedef enum logic [1:0] {IDLE, FLUSH, FILL, STREAM} state_t;

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(LINE_WIDTH - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(FRAME_HEIGHT - 1);

    state_t           state_q, state_d;
    logic             fval_q;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0] xc_q, xc_d, yc_q, yc_d;
    logic             win_q, win_d;
    logic             done_q, done_d;
    logic [2:0]       err_q, err_d;

    logic in_run, in_stream, accept, x_last, y_last;

    assign in_run    = (state_q == FILL) || (state_q == STREAM);
    assign in_stream = (state_q == STREAM);
    // A pixel arriving in the same cycle iFVAL drops belongs to no frame.
    assign accept    = in_run && iFVAL && iDVAL && !iRST;
    assign x_last    = (x_q == X_LAST);
    assign y_last    = (y_q == Y_LAST);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            fval_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            xc_q    <= '0;
            yc_q    <= '0;
            win_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            fval_q  <= iFVAL;
            x_q     <= x_d;
            y_q     <= y_d;
            xc_q    <= xc_d;
            yc_q    <= yc_d;
            win_q   <= win_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (iFVAL && !fval_q) state_d = FLUSH;
            FLUSH:  state_d = FILL;
            FILL: begin
                if (!iFVAL)                 state_d = IDLE;
                else if (iDVAL && x_last)   state_d = STREAM;
            end
            STREAM: begin
                if (!iFVAL)                           state_d = IDLE;
                else if (iDVAL && x_last && y_last)   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        oWREN  = accept;
        oRDEN  = accept && in_stream;
        oFLUSH = (state_q == FLUSH) && !iRST;
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        xc_d   = xc_q;
        yc_d   = yc_q;
        win_d  = 1'b0;
        done_d = 1'b0;
        err_d  = err_q;
        if (state_q == FLUSH) begin
            x_d   = '0;
            y_d   = '0;
            err_d = '0;
        end
        if (accept) begin
            xc_d = x_q;
            yc_d = y_q;
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + CNT_W'(1);
            end else begin
                x_d = x_q + CNT_W'(1);
            end
            win_d  = in_stream && x_q[0] && y_q[0];
            done_d = in_stream && x_last && y_last;
        end
        if (in_run && !iFVAL)                   err_d[2] = 1'b1;
        if (oRDEN && iFIFO_EMPTY)               err_d[1] = 1'b1;
        if (oWREN && iFIFO_FULL && !oRDEN)      err_d[0] = 1'b1;
    end

    assign oX_Cont     = xc_q;
    assign oY_Cont     = yc_q;
    assign oWIN_VALID  = win_q;
    assign oFRAME_DONE = done_q;
    assign oERR        = err_q;

endmodule

// File: tb/tb_bayer_line_ctrl.sv
// Random-frame bench for bayer_line_ctrl (8x4 frame) against a
// pixel-index reference model.
module tb_bayer_line_ctrl;

    localparam int LW   = 8;
    localparam int FH   = 4;
    localparam int CW   = 11;
    localparam int NPIX = LW * FH;

    logic          clk = 1'b0;
    logic          rst, fval, dval, full, empty;
    logic          wren, rden, flush, win, done;
    logic [CW-1:0] xc, yc;
    logic [2:0]    err;

    always #5 clk = ~clk;

    bayer_line_ctrl #(.LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .CNT_W(CW)) dut (
        .iCLK(clk), .iRST(rst), .iFVAL(fval), .iDVAL(dval),
        .iFIFO_FULL(full), .iFIFO_EMPTY(empty),
        .oWREN(wren), .oRDEN(rden), .oFLUSH(flush),
        .oX_Cont(xc), .oY_Cont(yc), .oWIN_VALID(win),
        .oFRAME_DONE(done), .oERR(err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 flush, 2 in frame; p = linear pixel index
    int       m_mode = 0;
    int       m_p = 0;
    bit       m_fprev = 0;
    bit [2:0] m_err = 0;
    int       m_xc = 0, m_yc = 0;
    bit       m_win = 0, m_done = 0;
    int       m_wins = 0;

    task automatic cyc(input bit r, input bit f, input bit d,
                       input bit fu, input bit em);
        bit act, acc, wr, rd, fl;
        @(negedge clk);
        rst = r; fval = f; dval = d; full = fu; empty = em;
        #1;
        act = !r && m_mode == 2 && f;
        acc = act && d;
        wr  = acc;
        rd  = acc && m_p >= LW;
        fl  = !r && m_mode == 1;
        chk("wren", 32'(wren), 32'(wr));
        chk("rden", 32'(rden), 32'(rd));
        chk("flush", 32'(flush), 32'(fl));
        @(posedge clk);
        #1;
        m_win  = 0;
        m_done = 0;
        if (r) begin
            m_mode = 0; m_p = 0; m_fprev = 0; m_err = 0;
            m_xc = 0; m_yc = 0;
        end else begin
            if (m_mode == 0) begin
                if (f && !m_fprev) m_mode = 1;
            end else if (m_mode == 1) begin
                m_p = 0; m_err = 0; m_mode = 2; m_wins = 0;
            end else begin
                if (!f) begin
                    m_err[2] = 1;
                    m_mode = 0;
                end else if (d) begin
                    m_xc = m_p % LW;
                    m_yc = m_p / LW;
                    m_win = (m_p >= LW) && (m_xc % 2 == 1) && (m_yc % 2 == 1);
                    m_done = (m_p == NPIX - 1);
                    if (m_win) m_wins++;
                    if (m_done) begin m_mode = 0; m_p = 0; end
                    else m_p++;
                end
                if (rd && em)       m_err[1] = 1;
                if (wr && fu && !rd) m_err[0] = 1;
            end
            m_fprev = f;
        end
        chk("x_cont", 32'(xc), 32'(m_xc));
        chk("y_cont", 32'(yc), 32'(m_yc));
        chk("win_valid", 32'(win), 32'(m_win));
        chk("frame_done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
        if (m_done) chk("win_count", 32'(m_wins), 32'((LW / 2) * (FH / 2)));
    endtask

    // dmode: 0 continuous, 1 toggling, 2 random; cut: cycle iFVAL drops;
    // fault: 1 random FIFO full, 2 random FIFO empty; rst_at: mid-frame reset
    task automatic frame(input int dmode, input int cut, input int fault,
                         input int rst_at);
        int t;
        bit f, d, r, fu, em;
        for (int i = 0; i < 3; i++) cyc(0, 0, bit'($urandom_range(0, 1)), 0, 0);
        t = 0;
        while (t < 400) begin
            f  = !(cut > 0 && t >= cut);
            r  = (rst_at > 0 && t == rst_at);
            d  = (dmode == 0) ? 1'b1 :
                 (dmode == 1) ? bit'(t % 2 == 0) : bit'($urandom_range(0, 1));
            fu = (fault == 1) && ($urandom_range(0, 1) == 0);
            em = (fault == 2) && ($urandom_range(0, 1) == 0);
            cyc(r, f, d, fu, em);
            t++;
            if (m_mode == 0 && t > 1) break;
        end
        if (t >= 400) chk("frame_bound", 32'(t), 32'(0));
    endtask

    initial begin
        rst = 1; fval = 1; dval = 1; full = 0; empty = 0;
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0);
        frame(0, 0, 0, 0);
        frame(1, 0, 0, 0);
        frame(0, 21, 0, 0);
        frame(0, 0, 2, 0);
        frame(0, 0, 1, 0);
        frame(2, 0, 0, 17);
        for (int k = 0; k < 14; k++)
            frame(int'($urandom_range(0, 2)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 40)) : 0,
                  int'($urandom_range(0, 2)),
                  ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, 40)) : 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
